// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (im side)
// and load/store (dm side). Each access occupies the memory for MEM_LAT cycles; the
// completion cycle doubles as the next issue opportunity.
// Optional build macro: ARB_RR_EN selects round-robin arbitration instead of the
// default fixed priority (DM over IF).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                dm_req,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_web,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_web,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic done;
  logic if_done;
  logic dm_done;
  logic can_issue;
  logic if_eff;
  logic dm_eff;
  logic grant_if;
  logic grant_dm;

`ifdef ARB_RR_EN
  logic last_dm;  // 1 when the most recent grant went to DM, 0 for IF
`endif

  // Completion detection, request qualification and arbitration for this cycle.
  // Issue is gated with rst so mem_en/mem_web drop asynchronously on reset even
  // while a request is still being held by the pipeline.
  always_comb begin
    done      = (state != IDLE) && (cnt == CNT_W'(1));
    if_done   = done && (state == BUSY_IF);
    dm_done   = done && (state == BUSY_DM);
    can_issue = !rst && ((state == IDLE) || done);
    // a requester's req in its own completion cycle still refers to that access
    if_eff    = if_req && !if_done;
    dm_eff    = dm_req && !dm_done;
`ifdef ARB_RR_EN
    grant_dm  = can_issue && dm_eff && (!if_eff || !last_dm);
`else
    grant_dm  = can_issue && dm_eff;
`endif
    grant_if  = can_issue && if_eff && !grant_dm;
  end

  // Memory-side and CPU-side outputs; all combinational from the current state.
  always_comb begin
    mem_en    = grant_if || grant_dm;
    mem_addr  = grant_dm ? dm_addr : if_addr;
    mem_wdata = dm_wdata;
    mem_web   = grant_dm ? dm_web : '0;
    if_valid  = if_done && !rst;
    dm_valid  = dm_done && !rst;
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
    stall_if  = !rst && if_req && !if_valid;
    stall_mem = !rst && dm_req && !dm_valid;
  end

  // Access sequencer: load latency counter on issue, count down while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (grant_dm) begin
      state <= BUSY_DM;
      cnt   <= CNT_W'(MEM_LAT);
    end else if (grant_if) begin
      state <= BUSY_IF;
      cnt   <= CNT_W'(MEM_LAT);
    end else if (done) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state != IDLE) begin
      cnt   <= cnt - CNT_W'(1);
    end
  end

`ifdef ARB_RR_EN
  // Remember the last winner so a simultaneous request alternates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dm <= 1'b0;
    end else if (grant_dm) begin
      last_dm <= 1'b1;
    end else if (grant_if) begin
      last_dm <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// reset/protocol sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_req;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [BW-1:0] dm_web;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_web;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_web(dm_web),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_web(mem_web),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory macro model: data returned LAT cycles after an issue is a hash of its address.
  logic          hv [16];
  logic [AW-1:0] ha [16];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  always @(posedge clk) begin
    hv[cyc % 16] <= mem_en;
    ha[cyc % 16] <= mem_addr;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin : mem_model
    int idx;
    idx = (cyc - LAT) % 16;
    if (cyc >= LAT && hv[idx]) mem_rdata = hash(ha[idx]);
    else                       mem_rdata = $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [3:0]  dweb;
    logic        en;
    logic [31:0] maddr;
    logic [3:0]  mweb;
    logic        iv;
    logic        dv;
    logic        sif;
    logic        sdm;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic [31:0] da, input logic [31:0] dwd,
                              input logic [3:0] dweb, input logic en,
                              input logic [31:0] ma, input logic [3:0] mw,
                              input logic iv, input logic dv, input logic sif,
                              input logic sdm);
    vec_t v;
    v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.daddr = da; v.dwd = dwd; v.dweb = dweb;
    v.en = en; v.maddr = ma; v.mweb = mw; v.iv = iv; v.dv = dv; v.sif = sif; v.sdm = sdm;
    return v;
  endfunction

  task automatic drive_idle();
    if_req = 0; if_addr = '0; dm_req = 0; dm_addr = '0; dm_wdata = '0; dm_web = '0;
  endtask

  // Transaction-level reference model state
  int          m_who;   // 0 none, 1 IF, 2 DM
  int          m_done;  // cycle number in which the in-flight access completes
  logic [31:0] m_addr;
  logic        m_load;
  int          m_last;  // last granted requester (1 IF, 2 DM)

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vq[$];
    vec_t v;
    logic if_act, dm_act, prev_iv, prev_dv;

    rst = 1'b1;
    drive_idle();

    // Reset: all outputs low, even with requests asserted during reset
    @(negedge clk); #1;
    chk("rst_mem_en", mem_en, 0);   chk("rst_mem_web", mem_web, 0);
    chk("rst_if_valid", if_valid, 0); chk("rst_dm_valid", dm_valid, 0);
    chk("rst_stall_if", stall_if, 0); chk("rst_stall_mem", stall_mem, 0);
    if_req = 1; dm_req = 1; dm_web = 4'hF;
    #1;
    chk("rst_req_mem_en", mem_en, 0); chk("rst_req_mem_web", mem_web, 0);
    chk("rst_req_stall_if", stall_if, 0); chk("rst_req_stall_mem", stall_mem, 0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_mem_en", mem_en, 0);
      chk("idle_valid", {if_valid, dm_valid}, 0);
      @(negedge clk);
    end

    // Directed vector table (MEM_LAT = 2)
    vq.push_back(mk(1, 32'h100, 0, 0, 0, 0,           1, 32'h100, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 32'h100, 0, 0, 0, 0,           0, 0, 0,       0, 0, 1, 0));
    vq.push_back(mk(1, 32'h100, 0, 0, 0, 0,           0, 0, 0,       1, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 1, 32'h2000, 4'b0011, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 0, 1, 0, 0));
`ifdef ARB_RR_EN
    vq.push_back(mk(1, 32'h200, 1, 32'h3000, 0, 0,    1, 32'h200, 0,  0, 0, 1, 1));
    vq.push_back(mk(1, 32'h200, 1, 32'h3000, 0, 0,    0, 0, 0,        0, 0, 1, 1));
    vq.push_back(mk(1, 32'h200, 1, 32'h3000, 0, 0,    1, 32'h3000, 0, 1, 0, 0, 1));
    vq.push_back(mk(0, 0, 1, 32'h3000, 0, 0,          0, 0, 0,        0, 0, 0, 1));
    vq.push_back(mk(0, 0, 1, 32'h3000, 0, 0,          0, 0, 0,        0, 1, 0, 0));
`else
    vq.push_back(mk(1, 32'h200, 1, 32'h3000, 0, 0,    1, 32'h3000, 0, 0, 0, 1, 1));
    vq.push_back(mk(1, 32'h200, 1, 32'h3000, 0, 0,    0, 0, 0,        0, 0, 1, 1));
    vq.push_back(mk(1, 32'h200, 1, 32'h3000, 0, 0,    1, 32'h200, 0,  0, 1, 1, 0));
    vq.push_back(mk(1, 32'h200, 0, 0, 0, 0,           0, 0, 0,        0, 0, 1, 0));
    vq.push_back(mk(1, 32'h200, 0, 0, 0, 0,           0, 0, 0,        1, 0, 0, 0));
`endif
    for (int a = 0; a < 12; a += 4) begin
      vq.push_back(mk(1, a, 0, 0, 0, 0,               1, a, 0,        0, 0, 1, 0));
      vq.push_back(mk(1, a, 0, 0, 0, 0,               0, 0, 0,        0, 0, 1, 0));
      vq.push_back(mk(1, a, 0, 0, 0, 0,               0, 0, 0,        1, 0, 0, 0));
    end
    vq.push_back(mk(0, 0, 0, 0, 0, 0,                 0, 0, 0,        0, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      if_req = v.ireq; if_addr = v.iaddr;
      dm_req = v.dreq; dm_addr = v.daddr; dm_wdata = v.dwd; dm_web = v.dweb;
      #1;
      chk("vec_mem_en", mem_en, v.en);
      chk("vec_mem_web", mem_web, v.mweb);
      chk("vec_if_valid", if_valid, v.iv);
      chk("vec_dm_valid", dm_valid, v.dv);
      chk("vec_stall_if", stall_if, v.sif);
      chk("vec_stall_mem", stall_mem, v.sdm);
      if (v.en) chk("vec_mem_addr", mem_addr, v.maddr);
      if (v.en && v.mweb != 0) chk("vec_mem_wdata", mem_wdata, v.dwd);
      if (v.iv) chk("vec_if_rdata", if_rdata, hash(v.iaddr));
      if (v.dv && v.dweb == 0) chk("vec_dm_rdata", dm_rdata, hash(v.daddr));
      @(negedge clk);
    end

    // Reset asserted in a store issue cycle: strobe and mask drop at once
    dm_req = 1; dm_addr = 32'h80; dm_wdata = 32'h1234_5678; dm_web = 4'hF;
    #1;
    chk("st_issue_en", mem_en, 1); chk("st_issue_web", mem_web, 4'hF);
    rst = 1; #1;
    chk("st_rst_en", mem_en, 0); chk("st_rst_web", mem_web, 0);
    chk("st_rst_stall", stall_mem, 0);
    drive_idle();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("st_rst_no_valid", {dm_valid, mem_en}, 0);
      @(negedge clk);
    end

    // Load issued at T0, reset pulsed at T1: no dm_valid afterwards
    dm_req = 1; dm_addr = 32'h40;
    #1; chk("ld_issue_en", mem_en, 1); chk("ld_issue_addr", mem_addr, 32'h40);
    @(negedge clk); #1;
    chk("ld_t1_stall", stall_mem, 1);
    rst = 1; dm_req = 0; #1;
    chk("ld_rst_stall", stall_mem, 0); chk("ld_rst_en", mem_en, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("ld_rst_no_valid", dm_valid, 0);
      @(negedge clk);
    end

    // First access after reset completes normally
    dm_req = 1; dm_addr = 32'h44;
    #1; chk("post_rst_en", mem_en, 1); chk("post_rst_addr", mem_addr, 32'h44);
    @(negedge clk); #1; chk("post_rst_t1_valid", dm_valid, 0);
    @(negedge clk); #1;
    chk("post_rst_valid", dm_valid, 1); chk("post_rst_rdata", dm_rdata, hash(32'h44));
    @(negedge clk);
    dm_req = 0;

    // Fetch request dropped mid-access still completes with a valid pulse
    if_req = 1; if_addr = 32'h48;
    #1; chk("drop_issue_en", mem_en, 1);
    @(negedge clk); if_req = 0;
    @(negedge clk); #1;
    chk("drop_valid", if_valid, 1); chk("drop_rdata", if_rdata, hash(32'h48));
    @(negedge clk); #1;
    chk("drop_after", {if_valid, mem_en}, 0);

    // Randomized traffic against the transaction-level model
    m_who = 0; m_done = 0; m_addr = '0; m_load = 1; m_last = 1;
    if_act = 0; dm_act = 0; prev_iv = 0; prev_dv = 0;
    drive_idle();
    for (int n = 0; n < 2000; n++) begin
      int   g;
      logic comp, eiv, edv, opp, ie, de;
      @(negedge clk);
      if (if_act && prev_iv) if_act = 0;
      if (!if_act && $urandom_range(0, 2) != 0) begin
        if_act = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if_req = if_act;
      if (dm_act && prev_dv) dm_act = 0;
      if (!dm_act && $urandom_range(0, 2) != 0) begin
        dm_act = 1; dm_addr = $urandom; dm_wdata = $urandom;
        dm_web = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      dm_req = dm_act;
      #1;
      comp = (m_who != 0) && (cyc == m_done);
      eiv  = comp && (m_who == 1);
      edv  = comp && (m_who == 2);
      opp  = (m_who == 0) || comp;
      ie   = if_req && !eiv;
      de   = dm_req && !edv;
      g    = 0;
      if (opp) begin
`ifdef ARB_RR_EN
        if (ie && de) g = (m_last == 2) ? 1 : 2;
`else
        if (ie && de) g = 2;
`endif
        else if (de) g = 2;
        else if (ie) g = 1;
      end
      chk("rnd_mem_en", mem_en, g != 0);
      chk("rnd_mem_web", mem_web, (g == 2) ? dm_web : 4'h0);
      chk("rnd_if_valid", if_valid, eiv);
      chk("rnd_dm_valid", dm_valid, edv);
      chk("rnd_stall_if", stall_if, if_req && !eiv);
      chk("rnd_stall_mem", stall_mem, dm_req && !edv);
      if (g != 0) chk("rnd_mem_addr", mem_addr, (g == 2) ? dm_addr : if_addr);
      if (g == 2 && dm_web != 0) chk("rnd_mem_wdata", mem_wdata, dm_wdata);
      if (eiv) chk("rnd_if_rdata", if_rdata, hash(m_addr));
      if (edv && m_load) chk("rnd_dm_rdata", dm_rdata, hash(m_addr));
      if (comp) m_who = 0;
      if (g != 0) begin
        m_who  = g;
        m_done = cyc + LAT;
        m_addr = (g == 2) ? dm_addr : if_addr;
        m_load = (g == 1) || (dm_web == 0);
        m_last = g;
      end
      prev_iv = eiv;
      prev_dv = edv;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
